conv_job_sequencer: RTL
=======================

# conv_job_sequencer

Host-side initiator for the binary 3x3 convolution accelerator. It accepts a stream of images from the host and packs them into the input SRAM with a terminator word. It then pulses `dut_run`, waits for `dut_busy` to fall, and streams the output SRAM rows back to the host with backpressure. It sits between the host/testbench fabric and the accelerator's two SRAM ports plus run/busy handshake.

## Interface
- `ADDR_W`, 12: SRAM address width.
- `DATA_W`, 16: SRAM word / stream width.
- `TIMEOUT_CYCLES`, 65535: watchdog limit on the run phase (used only with `SEQ_TIMEOUT_EN`).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a job; sampled only in S_IDLE.
- `in_valid` / `in_ready` in/out 1: load-stream handshake.
- `in_data` in DATA_W: header word (N in low 5 bits, N ∈ {10,12,16}) followed by N row words, repeated.
- `in_last` in 1: marks the final row of the final image.
- `isram_write_enable` out 1, `isram_write_address` out ADDR_W, `isram_write_data` out DATA_W: input SRAM write port.
- `dut_run` out 1: one-cycle start pulse to the accelerator.
- `dut_busy` in 1: accelerator busy.
- `osram_read_address` out ADDR_W: output SRAM read address.
- `osram_read_data` in DATA_W: read data, valid 1 cycle after the address.
- `out_valid` / `out_ready` out/in 1: result-stream handshake.
- `out_data` out DATA_W, `out_last` out 1: result rows; `out_last` is set on the final row.
- `done` out 1: one-cycle pulse at job end.
- `err` out 1, `err_code` out 2: sticky until the next accepted `start`. Codes: 1 = bad header, 2 = framing, 3 = timeout.

## Operation
- States: S_IDLE, S_LOAD, S_TERM, S_RUN, S_WAIT, S_DRAIN, S_DONE.
- S_IDLE → S_LOAD on `start`. This clears the write address, `out_rows`, `err` and `err_code`.
- S_LOAD:
  - `in_ready`=1. Each accepted word is written at `isram_write_address`, which then increments.
  - Header-expected phase: low 5 bits must be 10, 12 or 16, else `err_code`=1 → S_IDLE. Valid headers load `row_cnt`=N and add `out_rows += N-2`.
  - Row phase: decrement `row_cnt`.
  - Framing: `in_last` on a header, or `in_last` missing when the final row is accepted with the address at 2^ADDR_W-2, gives `err_code`=2 → S_IDLE. In both cases `dut_run` is never pulsed.
  - Valid `in_last` on the final row → S_TERM.
- S_TERM: write 16'h00FF at the next address; `in_ready`=0 → S_RUN.
- S_RUN: `dut_run`=1 for exactly one cycle → S_WAIT.
- S_WAIT: wait for `dut_busy` to rise, then fall. A fall after the rise → S_DRAIN with read pointer 0.
- S_DRAIN:
  - Issue reads 0..`out_rows`-1 into a 2-entry result FIFO.
  - A read issues only when (FIFO occupancy + in-flight) < 2.
  - `out_data` comes from the FIFO head; `out_last` is set when the popped index = `out_rows`-1.
  - After the last pop → S_DONE.
- S_DONE: `done`=1 for one cycle → S_IDLE.
- Input-SRAM write port is idle (`isram_write_enable`=0) outside S_LOAD/S_TERM.

## Timing
- Reset values: `in_ready`=0, `isram_write_enable`=0, both addresses=0, `isram_write_data`=0, `dut_run`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `done`=0, `err`=0, `err_code`=0, state S_IDLE.
- Reset mid-job: the next edge returns to S_IDLE. The FIFO and counters clear and any FIFO contents are discarded.
- Load throughput: one word per cycle. The write is registered, so `isram_write_enable` is high the cycle after the handshake.
- `dut_run` is asserted the cycle after the terminator write. `dut_busy` is expected at run+1.
- Read latency: 1 cycle. First `out_valid` appears 2 cycles after entering S_DRAIN.
- With `out_ready` held at 1, throughput is one row per cycle.
- `out_valid`/`out_data` stay stable while `out_ready`=0.
- `out_rows`=0 cannot occur, because at least one image is required.
- `start` outside S_IDLE is ignored.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles in S_WAIT.
  - Reaching `TIMEOUT_CYCLES` without a busy fall sets `err_code`=3 and goes → S_IDLE with no drain. The counter restarts on each S_WAIT entry.
- `SEQ_TIMEOUT_EN` undefined: S_WAIT waits indefinitely and the counter is not synthesized.

## Test plan
- One 10x10 image, `out_ready`=1, busy model 40 cycles:
  - 11 writes at addresses 0..10, then 16'h00FF at address 11.
  - One `dut_run` pulse.
  - 8 output rows with `out_last` on the 8th, then `done`.
- Three images (16, 12, 10) back to back:
  - `out_rows`=14+10+8=32.
  - Terminator at address 41.
  - 32 outputs delivered in order.
- Header 16'h000B: `err`=1, `err_code`=1, `dut_run` never asserted, state S_IDLE.
- Drain with `out_ready` toggling 1,0,0,1 pseudo-randomly: no row lost or duplicated, and data stays stable while stalled.
- `dut_busy` stuck high for 70000 cycles:
  - With `SEQ_TIMEOUT_EN`: `err_code`=3 after 65535 cycles.
  - Without it: still in S_WAIT.
- `reset` asserted during S_DRAIN: all outputs return to their reset values on the next edge, and a new `start` then completes normally.

Source files
------------

// File: rtl/conv_job_sequencer_if.sv
// Handshake and SRAM-port bundle between conv_job_sequencer and its environment.
// master: the sequencer; slave: host fabric, SRAMs and the accelerator.
interface conv_job_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              isram_write_enable;
  logic [ADDR_W-1:0] isram_write_address;
  logic [DATA_W-1:0] isram_write_data;
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] osram_read_address;
  logic [DATA_W-1:0] osram_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    input  start, in_valid, in_data, in_last, dut_busy, osram_read_data, out_ready,
    output in_ready, isram_write_enable, isram_write_address, isram_write_data,
           dut_run, osram_read_address, out_valid, out_data, out_last, done, err, err_code
  );

  modport slave (
    output start, in_valid, in_data, in_last, dut_busy, osram_read_data, out_ready,
    input  in_ready, isram_write_enable, isram_write_address, isram_write_data,
           dut_run, osram_read_address, out_valid, out_data, out_last, done, err, err_code
  );
endinterface

// File: rtl/conv_job_sequencer.sv
// Host-side job sequencer for the binary 3x3 convolution accelerator:
// loads images plus a terminator into the input SRAM, pulses run, waits for
// busy to fall, then streams output SRAM rows back through a 2-entry FIFO.
// Optional run-phase watchdog: define SEQ_TIMEOUT_EN.
module conv_job_sequencer #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  reset,
  conv_job_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TERM, S_RUN, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_wa, r_out_rows, r_rd, r_pop_cnt;
  logic [4:0]        r_row_cnt;
  logic              r_we, r_run, r_seen_busy, r_inflight, r_err;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_err_code;
  logic [DATA_W-1:0] r_q [2];
  logic              r_qwp, r_qrp;
  logic [1:0]        r_qcnt;

  logic              w_in_fire, w_is_hdr, w_hdr_ok, w_last_row, w_addr_full;
  logic              w_hdr_err, w_frame_err, w_load_done;
  logic              w_busy_fall, w_timeout, w_out_valid, w_pop, w_issue, w_last_pop;
  logic [4:0]        w_n;
  logic [1:0]        w_occ;
  logic [ADDR_W-1:0] w_last_idx;

  // Decode of the load stream, run handshake and drain FIFO conditions
  always_comb begin
    w_in_fire   = (r_state == S_LOAD) && bus.in_valid;
    w_n         = bus.in_data[4:0];
    w_is_hdr    = (r_row_cnt == 5'd0);
    w_hdr_ok    = (w_n == 5'd10) || (w_n == 5'd12) || (w_n == 5'd16);
    w_last_row  = !w_is_hdr && (r_row_cnt == 5'd1);
    w_addr_full = (r_addr == {{(ADDR_W-1){1'b1}}, 1'b0});
    w_hdr_err   = w_in_fire && w_is_hdr && !w_hdr_ok;
    w_frame_err = w_in_fire && ((w_is_hdr && w_hdr_ok && bus.in_last) ||
                                (w_last_row && !bus.in_last && w_addr_full));
    w_load_done = w_in_fire && w_last_row && bus.in_last;
    w_busy_fall = (r_state == S_WAIT) && r_seen_busy && !bus.dut_busy;
    w_out_valid = (r_state == S_DRAIN) && (r_qcnt != 2'd0);
    w_pop       = w_out_valid && bus.out_ready;
    w_last_idx  = r_out_rows - ADDR_W'(1);
    w_last_pop  = w_pop && (r_pop_cnt == w_last_idx);
    // Occupancy is taken after this cycle's pop so a steady ready stream
    // sustains one row per cycle without exceeding two FIFO slots.
    w_occ       = r_qcnt + {1'b0, r_inflight} - {1'b0, w_pop};
    w_issue     = (r_state == S_DRAIN) && (r_rd != r_out_rows) && (w_occ < 2'd2);
  end

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] r_wd;

  // Watchdog counting cycles spent in S_WAIT, restarted on every entry
  always_ff @(posedge clk) begin
    if (reset || r_state != S_WAIT) r_wd <= '0;
    else                            r_wd <= r_wd + 16'd1;
  end

  assign w_timeout = (r_state == S_WAIT) && !w_busy_fall &&
                     (r_wd == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_LOAD;
      S_LOAD:  if (w_hdr_err || w_frame_err) w_next = S_IDLE;
               else if (w_load_done)         w_next = S_TERM;
      S_TERM:  w_next = S_RUN;
      S_RUN:   w_next = S_WAIT;
      S_WAIT:  if (w_busy_fall)    w_next = S_DRAIN;
               else if (w_timeout) w_next = S_IDLE;
      S_DRAIN: if (w_last_pop) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready            = (r_state == S_LOAD);
    bus.done                = (r_state == S_DONE);
    bus.out_valid           = w_out_valid;
    bus.out_data            = w_out_valid ? r_q[r_qrp] : '0;
    bus.out_last            = w_out_valid && (r_pop_cnt == w_last_idx);
    bus.dut_run             = r_run;
    bus.isram_write_enable  = r_we;
    bus.isram_write_address = r_wa;
    bus.isram_write_data    = r_wdata;
    bus.osram_read_address  = r_rd;
    bus.err                 = r_err;
    bus.err_code            = r_err_code;
  end

  // Load path, terminator write, run pulse, busy tracking and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0; r_wa <= '0; r_wdata <= '0; r_we <= 1'b0; r_run <= 1'b0;
      r_out_rows <= '0; r_row_cnt <= '0; r_seen_busy <= 1'b0;
      r_err <= 1'b0; r_err_code <= '0;
    end else begin
      r_we  <= 1'b0;
      r_run <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_addr <= '0; r_out_rows <= '0; r_row_cnt <= '0;
          r_err <= 1'b0; r_err_code <= '0;
        end
        S_LOAD: if (w_in_fire) begin
          r_we    <= 1'b1;
          r_wa    <= r_addr;
          r_wdata <= bus.in_data;
          r_addr  <= r_addr + ADDR_W'(1);
          if (w_hdr_err) begin
            r_err <= 1'b1; r_err_code <= 2'd1;
          end else if (w_frame_err) begin
            r_err <= 1'b1; r_err_code <= 2'd2;
          end else if (w_is_hdr) begin
            r_row_cnt  <= w_n;
            r_out_rows <= r_out_rows + ADDR_W'(w_n) - ADDR_W'(2);
          end else begin
            r_row_cnt <= r_row_cnt - 5'd1;
          end
        end
        S_TERM: begin
          r_we    <= 1'b1;
          r_wa    <= r_addr;
          r_wdata <= DATA_W'(16'h00FF);
          r_addr  <= r_addr + ADDR_W'(1);
        end
        S_RUN:  r_seen_busy <= 1'b0;
        S_WAIT: begin
          if (bus.dut_busy) r_seen_busy <= 1'b1;
          if (w_timeout) begin
            r_err <= 1'b1; r_err_code <= 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

  // Output-SRAM read issue and 2-entry result FIFO
  always_ff @(posedge clk) begin
    if (reset || w_busy_fall) begin
      r_rd <= '0; r_pop_cnt <= '0; r_inflight <= 1'b0;
      r_qwp <= 1'b0; r_qrp <= 1'b0; r_qcnt <= '0;
    end else if (r_state == S_DRAIN) begin
      r_inflight <= w_issue;
      if (w_issue) r_rd <= r_rd + ADDR_W'(1);
      if (r_inflight) begin
        r_q[r_qwp] <= bus.osram_read_data;
        r_qwp      <= ~r_qwp;
      end
      if (w_pop) begin
        r_qrp     <= ~r_qrp;
        r_pop_cnt <= r_pop_cnt + ADDR_W'(1);
      end
      r_qcnt <= r_qcnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
